uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter clocks_per_bit, default 16, clock cycles per serial bit; legal range 4..65535.
REQ-002 SHALL have port clock  input  1  sole clock; all state changes on rising edge.
REQ-003 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port pin  input  1  asynchronous serial line, idle high.
REQ-005 SHALL have port byte_received  output  8  last correctly framed data byte.
REQ-006 SHALL have port valid  output  1  one-cycle pulse when byte_received is updated.
REQ-007 SHALL have port frame_error  output  1  one-cycle pulse when a stop bit is sampled low.

Function
REQ-008 SHALL accept frames of 1 start bit (low), 8 data bits LSB first, 1 stop bit (high); no parity.
REQ-009 SHALL pass pin through a 2-flop synchronizer; all decisions use the synchronized value (sync_pin).
REQ-010 SHALL implement states IDLE, START, DATA, STOP, with bit counter width $clog2(clocks_per_bit)+1 and bit index 0..7.
REQ-011 IDLE: SHALL arm only after sync_pin has been high for at least one cycle since entering IDLE.
REQ-012 IDLE, armed, sync_pin low: SHALL go to START with counter cleared.
REQ-013 START: SHALL sample when counter == clocks_per_bit/2 (integer division); low -> DATA, counter cleared, bit index 0; high -> IDLE (glitch rejected, no output pulse).
REQ-014 DATA: SHALL sample when counter == clocks_per_bit-1, shift the sample into bit [bit index], clear counter; after bit index 7 -> STOP.
REQ-015 STOP: SHALL sample when counter == clocks_per_bit-1, then return to IDLE.
REQ-016 Stop sample high: SHALL load byte_received and pulse valid high for exactly the cycle after the sample edge.
REQ-017 Stop sample low: SHALL pulse frame_error for one cycle, leave byte_received unchanged, and not pulse valid.
REQ-018 valid and frame_error SHALL never be high in the same cycle.
REQ-019 byte_received SHALL hold its value between valid pulses.
REQ-020 Back-to-back frames: a start edge arriving immediately after the stop-bit sample SHALL be received without loss.
REQ-021 Line held low after a frame error (break) SHALL NOT start a new frame until the line returns high (REQ-011).
REQ-022 Latency: valid SHALL rise 2 + clocks_per_bit/2 + 9*clocks_per_bit + 1 cycles (±1) after pin falls at the start bit.

Reset
REQ-023 reset_n low SHALL immediately force state IDLE (unarmed), counter 0, bit index 0, byte_received 8'h00, valid 0, frame_error 0, synchronizer flops 1.
REQ-024 Reset asserted mid-frame SHALL discard the partial frame with no valid or frame_error pulse.
REQ-025 After reset_n deasserts, reception SHALL resume on the first armed falling edge.

Configuration
REQ-026 Macro UART_RX_MAJORITY_EN defined: each start, data and stop decision SHALL be the 2-of-3 majority of sync_pin at the sample cycle and the two preceding cycles; latency unchanged.
REQ-027 Macro undefined: each decision SHALL be the single sync_pin value at the sample cycle.

Verification
REQ-028 clocks_per_bit=16, send 0xA5 with a valid stop bit -> single valid pulse, byte_received=0xA5, frame_error stays 0, latency per REQ-022.
REQ-029 Pin low for 4 cycles, then high -> FSM returns to IDLE, no valid or frame_error, byte_received unchanged.
REQ-030 Send 0x3C with stop bit low, line then held low for 40 bit times, then high, then 0x55 -> one frame_error, byte_received retains prior value, then valid with 0x55, nothing received during the break.
REQ-031 0x00 then 0xFF back-to-back, no idle gap -> two valid pulses, byte values 0x00 then 0xFF.
REQ-032 reset_n pulsed low during data bit 4 of 0x81, then 0x7E sent -> no pulse for 0x81, byte_received=0x00 after reset, then valid with 0x7E.
REQ-033 One-cycle high glitch on pin aligned to data bit 0 sample point of 0x00 -> 0x01 with UART_RX_MAJORITY_EN undefined, 0x00 with it defined.

Source files
------------

// File: rtl/uart_rx.sv
// UART receiver: 8N1 frames, 2-flop synchronized input, mid-bit sampling.
// Define UART_RX_MAJORITY_EN for 2-of-3 majority voting on each bit decision.
module uart_rx #(
  parameter int clocks_per_bit = 16
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       pin,
  output logic [7:0] byte_received,
  output logic       valid,
  output logic       frame_error
);

  localparam int CW = $clog2(clocks_per_bit) + 1;
  localparam logic [CW-1:0] HALF = CW'(clocks_per_bit / 2);
  localparam logic [CW-1:0] LAST = CW'(clocks_per_bit - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state;
  logic          s1, sync_pin, armed, bit_val;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [7:0]    shreg;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1       <= 1'b1;
      sync_pin <= 1'b1;
    end else begin
      s1       <= pin;
      sync_pin <= s1;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  // Two previous sync_pin samples feed the vote; sample latency is unchanged.
  logic h1, h2;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      h1 <= 1'b1;
      h2 <= 1'b1;
    end else begin
      h1 <= sync_pin;
      h2 <= h1;
    end
  end
  assign bit_val = (sync_pin & h1) | (sync_pin & h2) | (h1 & h2);
`else
  assign bit_val = sync_pin;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      armed         <= 1'b0;
      cnt           <= '0;
      idx           <= '0;
      shreg         <= '0;
      byte_received <= 8'h00;
      valid         <= 1'b0;
      frame_error   <= 1'b0;
    end else begin
      valid       <= 1'b0;
      frame_error <= 1'b0;
      case (state)
        IDLE: begin
          // Arming requires a high line first, so a held break never starts a frame.
          if (armed && !sync_pin) begin
            state <= START;
            armed <= 1'b0;
            cnt   <= '0;
          end else begin
            armed <= armed | sync_pin;
          end
        end
        START: begin
          if (cnt == HALF) begin
            cnt <= '0;
            idx <= '0;
            state <= bit_val ? IDLE : DATA;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DATA: begin
          if (cnt == LAST) begin
            cnt        <= '0;
            shreg[idx] <= bit_val;
            if (idx == 3'd7) state <= STOP;
            else             idx   <= idx + 3'd1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        STOP: begin
          if (cnt == LAST) begin
            cnt   <= '0;
            idx   <= '0;
            state <= IDLE;
            if (bit_val) begin
              byte_received <= shreg;
              valid         <= 1'b1;
            end else begin
              frame_error   <= 1'b1;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx at clocks_per_bit=16.
module tb_uart_rx;

  localparam int CPB = 16;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       pin = 1'b1;
  logic [7:0] byte_received;
  logic       valid, frame_error;

  uart_rx #(.clocks_per_bit(CPB)) dut (
    .clock(clock), .reset_n(reset_n), .pin(pin),
    .byte_received(byte_received), .valid(valid), .frame_error(frame_error)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       fe;
    logic [7:0] b;
  } exp_t;

  exp_t q[$];
  int n_cmp = 0, n_fail = 0;
  int cyc = 0, fall_cyc = 0, last_valid_cyc = 0;
  int n_valid = 0, n_fe = 0;

  always @(posedge clock) cyc <= cyc + 1;

  // Output monitor: every pulse must match the head of the expectation queue.
  always @(negedge clock) begin
    if (valid && frame_error) begin
      n_cmp++; n_fail++;
      $display("FAIL both_pulses: valid=%b frame_error=%b required not both high", valid, frame_error);
    end
    if (valid || frame_error) begin
      exp_t e;
      if (valid) begin n_valid++; last_valid_cyc = cyc; end
      if (frame_error) n_fe++;
      n_cmp++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_pulse: valid=%b frame_error=%b byte=%h, required no pulse",
                 valid, frame_error, byte_received);
      end else begin
        e = q.pop_front();
        if (frame_error !== e.fe || (!e.fe && byte_received !== e.b)) begin
          n_fail++;
          $display("FAIL pulse_data: fe=%b byte=%h, required fe=%b byte=%h",
                   frame_error, byte_received, e.fe, e.b);
        end
      end
    end
  end

  task automatic send_bit(input logic v, input int bits);
    pin = v;
    repeat (bits * CPB) @(negedge clock);
  endtask

  // Caller must be at a negedge; stop_bits of 0 means no stop bit driven.
  task automatic send_frame(input logic [7:0] d, input logic stop_v, input int stop_bits);
    fall_cyc = cyc;
    send_bit(1'b0, 1);
    for (int i = 0; i < 8; i++) send_bit(d[i], 1);
    if (stop_bits > 0) send_bit(stop_v, stop_bits);
  endtask

  task automatic push(input logic fe, input logic [7:0] b);
    exp_t e;
    e.fe = fe; e.b = b;
    q.push_back(e);
  endtask

  task automatic drain(input string name);
    int t = 0;
    while (q.size() != 0 && t < 20 * CPB) begin
      @(negedge clock); t++;
    end
    n_cmp++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_timeout: %0d pulses outstanding, required 0", name, q.size());
      q.delete();
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    n_cmp++;
    if ({byte_received, valid, frame_error} !== 10'h000) begin
      n_fail++;
      $display("FAIL reset_state: byte=%h valid=%b fe=%b, required 00 0 0", byte_received, valid, frame_error);
    end
    reset_n = 1'b1;
    repeat (2 * CPB) @(negedge clock);
  endtask

  task automatic test_basic;
    int lat;
    push(1'b0, 8'hA5);
    send_frame(8'hA5, 1'b1, 2);
    drain("basic");
    lat = last_valid_cyc - fall_cyc;
    n_cmp++;
    if (lat < 154 || lat > 156) begin
      n_fail++;
      $display("FAIL basic_latency: got %0d cycles, required 155 +/-1", lat);
    end
    n_cmp++;
    if (n_fe !== 0 || n_valid !== 1) begin
      n_fail++;
      $display("FAIL basic_counts: valid=%0d fe=%0d, required 1 0", n_valid, n_fe);
    end
  endtask

  task automatic test_start_glitch;
    int v0 = n_valid, f0 = n_fe;
    pin = 1'b0;
    repeat (4) @(negedge clock);
    pin = 1'b1;
    repeat (3 * CPB) @(negedge clock);
    n_cmp++;
    if (n_valid !== v0 || n_fe !== f0 || byte_received !== 8'hA5) begin
      n_fail++;
      $display("FAIL start_glitch: dv=%0d dfe=%0d byte=%h, required 0 0 a5",
               n_valid - v0, n_fe - f0, byte_received);
    end
  endtask

  task automatic test_frame_error_break;
    int v0 = n_valid, f0 = n_fe;
    push(1'b1, 8'h00);
    send_frame(8'h3C, 1'b0, 41);
    drain("ferr");
    n_cmp++;
    if (n_fe - f0 !== 1 || n_valid !== v0 || byte_received !== 8'hA5) begin
      n_fail++;
      $display("FAIL break: dfe=%0d dv=%0d byte=%h, required 1 0 a5",
               n_fe - f0, n_valid - v0, byte_received);
    end
    send_bit(1'b1, 2);
    push(1'b0, 8'h55);
    send_frame(8'h55, 1'b1, 2);
    drain("after_break");
    n_cmp++;
    if (byte_received !== 8'h55) begin
      n_fail++;
      $display("FAIL after_break_byte: got %h, required 55", byte_received);
    end
  endtask

  task automatic test_back_to_back;
    int v0 = n_valid;
    push(1'b0, 8'h00);
    push(1'b0, 8'hFF);
    send_frame(8'h00, 1'b1, 1);
    send_frame(8'hFF, 1'b1, 2);
    drain("b2b");
    n_cmp++;
    if (n_valid - v0 !== 2 || byte_received !== 8'hFF) begin
      n_fail++;
      $display("FAIL b2b: dv=%0d byte=%h, required 2 ff", n_valid - v0, byte_received);
    end
  endtask

  task automatic test_reset_midframe;
    int v0 = n_valid, f0 = n_fe;
    fork
      send_frame(8'h81, 1'b1, 2);
      begin
        repeat (5 * CPB + CPB / 2) @(negedge clock);
        reset_n = 1'b0;
        @(negedge clock);
        n_cmp++;
        if (byte_received !== 8'h00 || valid !== 1'b0) begin
          n_fail++;
          $display("FAIL midframe_reset: byte=%h valid=%b, required 00 0", byte_received, valid);
        end
      end
    join
    reset_n = 1'b1;
    send_bit(1'b1, 1);
    n_cmp++;
    if (n_valid !== v0 || n_fe !== f0) begin
      n_fail++;
      $display("FAIL partial_discard: dv=%0d dfe=%0d, required 0 0", n_valid - v0, n_fe - f0);
    end
    push(1'b0, 8'h7E);
    send_frame(8'h7E, 1'b1, 2);
    drain("post_reset");
    n_cmp++;
    if (byte_received !== 8'h7E) begin
      n_fail++;
      $display("FAIL post_reset_byte: got %h, required 7e", byte_received);
    end
  endtask

  task automatic test_data_glitch;
    logic [7:0] exp_b;
`ifdef UART_RX_MAJORITY_EN
    exp_b = 8'h00;
`else
    exp_b = 8'h01;
`endif
    push(1'b0, exp_b);
    // Glitch is timed so the synchronizer presents it exactly at the bit-0 sample.
    fork
      send_frame(8'h00, 1'b1, 2);
      begin
        repeat (4 + CPB / 2 + CPB - 3) @(negedge clock);
        pin = 1'b1;
        @(negedge clock);
        pin = 1'b0;
      end
    join
    drain("data_glitch");
    n_cmp++;
    if (byte_received !== exp_b) begin
      n_fail++;
      $display("FAIL data_glitch_byte: got %h, required %h", byte_received, exp_b);
    end
  endtask

  initial begin
    @(negedge clock);
    test_reset;
    test_basic;
    test_start_glitch;
    test_frame_error_break;
    test_back_to_back;
    test_reset_midframe;
    test_data_glitch;
    repeat (CPB) @(negedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
